// File: rtl/rx_cmd_pkg.sv
// rtl/rx_cmd_pkg.sv - opcodes, FSM encoding and gap-counter width shared by rx_cmd_ctrl and rx_cmd_timeout
package rx_cmd_pkg;

  localparam logic [7:0] OP_REG_WR  = 8'hAA;
  localparam logic [7:0] OP_REG_RD  = 8'hBB;
  localparam logic [7:0] OP_ALU_OPS = 8'hCC;
  localparam logic [7:0] OP_ALU_NOP = 8'hDD;

  // Wide enough for any sane inter-byte gap; TIMEOUT_CYCLES is range-checked against it.
  localparam int TMO_W = 16;

  typedef enum logic [3:0] {
    IDLE,
    WR_ADDR,
    WR_DATA,
    RD_ADDR,
    RD_WAIT,
    OPA,
    OPB,
    ALU_FUN,
    ALU_WAIT,
    TX_LO,
    TX_HI
  } state_t;

  // States that are waiting on the next byte of a frame from the host.
  function automatic logic gap_timed(input state_t s);
    return (s == WR_ADDR) || (s == WR_DATA) || (s == RD_ADDR) ||
           (s == OPA) || (s == OPB) || (s == ALU_FUN);
  endfunction

endpackage

// File: rtl/rx_cmd_timeout.sv
// rtl/rx_cmd_timeout.sv - inter-byte gap counter; flags a stalled frame after TIMEOUT_CYCLES idle cycles
module rx_cmd_timeout
  import rx_cmd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic CLK,
  input  logic RST,
  input  logic active,
  input  logic reload,
  output logic expired
);

  logic [TMO_W-1:0] cnt;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt <= '0;
    end else if (!active || reload) begin
      cnt <= '0;
    end else if (!expired) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = active && !reload && (cnt == TMO_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/rx_cmd_ctrl.sv
// rtl/rx_cmd_ctrl.sv - UART command decoder driving register file, ALU and TX FIFO
// Optional inter-byte gap timeout is built only when RX_CMD_TIMEOUT_EN is defined.
module rx_cmd_ctrl
  import rx_cmd_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 4,
  parameter int ALU_OUT_WIDTH  = 16,
  parameter int FUN_WIDTH      = 4,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     rx_valid,
  input  logic [DATA_WIDTH-1:0]    rx_data,
  output logic                     rf_wr_en,
  output logic                     rf_rd_en,
  output logic [ADDR_WIDTH-1:0]    rf_addr,
  output logic [DATA_WIDTH-1:0]    rf_wr_data,
  input  logic [DATA_WIDTH-1:0]    rf_rd_data,
  input  logic                     rf_rd_valid,
  output logic                     alu_en,
  output logic [FUN_WIDTH-1:0]     alu_fun,
  input  logic [ALU_OUT_WIDTH-1:0] alu_out,
  input  logic                     alu_out_valid,
  output logic                     tx_wr_en,
  output logic [DATA_WIDTH-1:0]    tx_data,
  input  logic                     tx_full,
  output logic                     clk_gate_en,
  output logic                     frame_err
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES >= (1 << TMO_W)) begin : g_bad_timeout
    $error("rx_cmd_ctrl: TIMEOUT_CYCLES out of range");
  end

  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   hi_byte_q, hi_byte_d;
  logic                    send_hi_q, send_hi_d;
  logic                    timeout_hit;

  logic                    rf_wr_en_d, rf_rd_en_d, alu_en_d, tx_wr_en_d;
  logic                    clk_gate_en_d, frame_err_d;
  logic [ADDR_WIDTH-1:0]   rf_addr_d;
  logic [DATA_WIDTH-1:0]   rf_wr_data_d, tx_data_d;
  logic [FUN_WIDTH-1:0]    alu_fun_d;

`ifdef RX_CMD_TIMEOUT_EN
  logic tmo_active;
  assign tmo_active = gap_timed(state_q);

  rx_cmd_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .CLK     (CLK),
    .RST     (RST),
    .active  (tmo_active),
    .reload  (rx_valid),
    .expired (timeout_hit)
  );
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    hi_byte_d    = hi_byte_q;
    send_hi_d    = send_hi_q;
    rf_wr_en_d   = 1'b0;
    rf_rd_en_d   = 1'b0;
    alu_en_d     = 1'b0;
    tx_wr_en_d   = 1'b0;
    frame_err_d  = 1'b0;
    rf_addr_d    = rf_addr;
    rf_wr_data_d = rf_wr_data;
    tx_data_d    = tx_data;
    alu_fun_d    = alu_fun;

    case (state_q)
      IDLE: begin
        if (rx_valid) begin
          if (rx_data == DATA_WIDTH'(OP_REG_WR))       state_d = WR_ADDR;
          else if (rx_data == DATA_WIDTH'(OP_REG_RD))  state_d = RD_ADDR;
          else if (rx_data == DATA_WIDTH'(OP_ALU_OPS)) state_d = OPA;
          else if (rx_data == DATA_WIDTH'(OP_ALU_NOP)) state_d = ALU_FUN;
          else                                         frame_err_d = 1'b1;
        end
      end
      WR_ADDR: begin
        if (rx_valid) begin
          rf_addr_d = rx_data[ADDR_WIDTH-1:0];
          state_d   = WR_DATA;
        end
      end
      WR_DATA: begin
        if (rx_valid) begin
          rf_wr_en_d   = 1'b1;
          rf_wr_data_d = rx_data;
          state_d      = IDLE;
        end
      end
      RD_ADDR: begin
        if (rx_valid) begin
          rf_addr_d  = rx_data[ADDR_WIDTH-1:0];
          rf_rd_en_d = 1'b1;
          state_d    = RD_WAIT;
        end
      end
      RD_WAIT: begin
        frame_err_d = rx_valid;
        if (rf_rd_valid) begin
          tx_data_d = rf_rd_data;
          send_hi_d = 1'b0;
          state_d   = TX_LO;
        end
      end
      OPA, OPB: begin
        if (rx_valid) begin
          rf_wr_en_d   = 1'b1;
          rf_addr_d    = (state_q == OPA) ? ADDR_WIDTH'(0) : ADDR_WIDTH'(1);
          rf_wr_data_d = rx_data;
          state_d      = (state_q == OPA) ? OPB : ALU_FUN;
        end
      end
      ALU_FUN: begin
        if (rx_valid) begin
          alu_en_d  = 1'b1;
          alu_fun_d = rx_data[FUN_WIDTH-1:0];
          state_d   = ALU_WAIT;
        end
      end
      ALU_WAIT: begin
        frame_err_d = rx_valid;
        if (alu_out_valid) begin
          tx_data_d = alu_out[DATA_WIDTH-1:0];
          hi_byte_d = alu_out[2*DATA_WIDTH-1 -: DATA_WIDTH];
          send_hi_d = 1'b1;
          state_d   = TX_LO;
        end
      end
      TX_LO: begin
        frame_err_d = rx_valid;
        if (!tx_full) begin
          tx_wr_en_d = 1'b1;
          state_d    = send_hi_q ? TX_HI : IDLE;
        end
      end
      TX_HI: begin
        // The LSB push (if any) completes this cycle, so the MSB can be staged now.
        frame_err_d = rx_valid;
        tx_data_d   = hi_byte_q;
        if (!tx_full) begin
          tx_wr_en_d = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (timeout_hit && !rx_valid) begin
      state_d     = IDLE;
      frame_err_d = 1'b1;
    end

    clk_gate_en_d = (state_d == OPA) || (state_d == OPB) ||
                    (state_d == ALU_FUN) || (state_d == ALU_WAIT);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= IDLE;
      hi_byte_q   <= '0;
      send_hi_q   <= 1'b0;
      rf_wr_en    <= 1'b0;
      rf_rd_en    <= 1'b0;
      rf_addr     <= '0;
      rf_wr_data  <= '0;
      alu_en      <= 1'b0;
      alu_fun     <= '0;
      tx_wr_en    <= 1'b0;
      tx_data     <= '0;
      clk_gate_en <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      state_q     <= state_d;
      hi_byte_q   <= hi_byte_d;
      send_hi_q   <= send_hi_d;
      rf_wr_en    <= rf_wr_en_d;
      rf_rd_en    <= rf_rd_en_d;
      rf_addr     <= rf_addr_d;
      rf_wr_data  <= rf_wr_data_d;
      alu_en      <= alu_en_d;
      alu_fun     <= alu_fun_d;
      tx_wr_en    <= tx_wr_en_d;
      tx_data     <= tx_data_d;
      clk_gate_en <= clk_gate_en_d;
      frame_err   <= frame_err_d;
    end
  end

endmodule

// File: tb/tb_rx_cmd_ctrl.sv
// tb/tb_rx_cmd_ctrl.sv - scoreboard bench for rx_cmd_ctrl command decoding, RF/ALU handshakes and TX pushes
module tb_rx_cmd_ctrl;
  localparam int DW  = 8;
  localparam int AW  = 4;
  localparam int OW  = 16;
  localparam int FW  = 4;
  localparam int TMO = 8;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          rx_valid = 1'b0;
  logic [DW-1:0] rx_data = '0;
  logic          rf_wr_en, rf_rd_en, alu_en, tx_wr_en, clk_gate_en, frame_err;
  logic [AW-1:0] rf_addr;
  logic [DW-1:0] rf_wr_data, tx_data;
  logic [DW-1:0] rf_rd_data = '0;
  logic          rf_rd_valid = 1'b0;
  logic [FW-1:0] alu_fun;
  logic [OW-1:0] alu_out = '0;
  logic          alu_out_valid = 1'b0;
  logic          tx_full = 1'b0;

  always #5 CLK = ~CLK;

  rx_cmd_ctrl #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ALU_OUT_WIDTH(OW), .FUN_WIDTH(FW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .CLK(CLK), .RST(RST), .rx_valid(rx_valid), .rx_data(rx_data),
    .rf_wr_en(rf_wr_en), .rf_rd_en(rf_rd_en), .rf_addr(rf_addr), .rf_wr_data(rf_wr_data),
    .rf_rd_data(rf_rd_data), .rf_rd_valid(rf_rd_valid),
    .alu_en(alu_en), .alu_fun(alu_fun), .alu_out(alu_out), .alu_out_valid(alu_out_valid),
    .tx_wr_en(tx_wr_en), .tx_data(tx_data), .tx_full(tx_full),
    .clk_gate_en(clk_gate_en), .frame_err(frame_err)
  );

  int tests = 0;
  int fails = 0;
  int ferr_seen = 0;
  int ferr_exp = 0;
  int tx_seen = 0;

  logic [AW+DW-1:0] exp_wr[$];
  logic [AW-1:0]    exp_rd[$];
  logic [FW-1:0]    exp_alu[$];
  logic [DW-1:0]    exp_tx[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  logic [AW+DW-1:0] m_wr;
  logic [AW-1:0]    m_rd;
  logic [FW-1:0]    m_fun;
  logic [DW-1:0]    m_tx;
  int               m_n;

  always @(negedge CLK) begin
    if (RST) begin
      m_n = int'(rf_wr_en) + int'(rf_rd_en) + int'(alu_en) + int'(tx_wr_en);
      if (m_n != 0) check("one_strobe", m_n, 1);
      if (rf_wr_en) begin
        check("wr_expected", exp_wr.size() != 0, 1);
        if (exp_wr.size() != 0) begin
          m_wr = exp_wr.pop_front();
          check("wr_addr", rf_addr, m_wr[AW+DW-1:DW]);
          check("wr_data", rf_wr_data, m_wr[DW-1:0]);
        end
      end
      if (rf_rd_en) begin
        check("rd_expected", exp_rd.size() != 0, 1);
        if (exp_rd.size() != 0) begin
          m_rd = exp_rd.pop_front();
          check("rd_addr", rf_addr, m_rd);
        end
      end
      if (alu_en) begin
        check("alu_expected", exp_alu.size() != 0, 1);
        check("alu_gate_on", clk_gate_en, 1);
        if (exp_alu.size() != 0) begin
          m_fun = exp_alu.pop_front();
          check("alu_fun", alu_fun, m_fun);
        end
      end
      if (tx_wr_en) begin
        tx_seen++;
        check("tx_expected", exp_tx.size() != 0, 1);
        check("tx_gate_off", clk_gate_en, 0);
        if (exp_tx.size() != 0) begin
          m_tx = exp_tx.pop_front();
          check("tx_data", tx_data, m_tx);
        end
      end
      if (frame_err) ferr_seen++;
    end
  end

  task automatic send(input logic [DW-1:0] b);
    @(negedge CLK);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge CLK);
    rx_valid = 1'b0;
    rx_data  = '0;
  endtask

  task automatic wait_tx(input string tag, input int limit);
    int  k;
    bit  hit;
    k   = 0;
    hit = 0;
    while (!hit && k < limit) begin
      @(negedge CLK);
      k++;
      hit = tx_wr_en;
    end
    check({tag, "_seen"}, hit, 1);
  endtask

  task automatic settle_and_audit(input string tag);
    repeat (6) @(negedge CLK);
    check({tag, "_wr_q"},  exp_wr.size(),  0);
    check({tag, "_rd_q"},  exp_rd.size(),  0);
    check({tag, "_alu_q"}, exp_alu.size(), 0);
    check({tag, "_tx_q"},  exp_tx.size(),  0);
    check({tag, "_ferr"},  ferr_seen,      ferr_exp);
  endtask

  initial begin
    repeat (3) @(negedge CLK);
    check("rst_wr_en", rf_wr_en, 0);
    check("rst_addr", rf_addr, 0);
    check("rst_tx", {tx_wr_en, tx_data}, 0);
    check("rst_gate_ferr", {clk_gate_en, frame_err, alu_en, rf_rd_en}, 0);
    RST = 1'b1;
    repeat (2) @(negedge CLK);

    // Register write
    exp_wr.push_back({4'h5, 8'h3C});
    send(8'hAA);
    send(8'h05);
    send(8'h3C);
    check("wr_latency", rf_wr_en, 1);
    @(negedge CLK);
    check("wr_single_pulse", rf_wr_en, 0);
    settle_and_audit("regwr");
    check("regwr_no_tx", tx_seen, 0);

    // Register read with back-pressure and a stray byte while the push is pending
    tx_full = 1'b1;
    exp_rd.push_back(4'h7);
    exp_tx.push_back(8'h99);
    send(8'hBB);
    send(8'h07);
    check("rd_latency", rf_rd_en, 1);
    @(negedge CLK);
    @(negedge CLK);
    rf_rd_valid = 1'b1;
    rf_rd_data  = 8'h99;
    @(negedge CLK);
    rf_rd_valid = 1'b0;
    rf_rd_data  = 8'h00;
    ferr_exp++;
    send(8'h77);
    check("tx_busy_ferr", frame_err, 1);
    @(negedge CLK);
    check("tx_held_while_full", tx_seen, 0);
    tx_full = 1'b0;
    wait_tx("rd_tx", 10);
    settle_and_audit("regrd");
    check("regrd_tx_count", tx_seen, 1);

    // ALU with operands
    check("gate_idle", clk_gate_en, 0);
    exp_wr.push_back({4'h0, 8'h12});
    exp_wr.push_back({4'h1, 8'h34});
    exp_alu.push_back(4'h0);
    exp_tx.push_back(8'h46);
    exp_tx.push_back(8'h00);
    send(8'hCC);
    check("gate_opa", clk_gate_en, 1);
    send(8'h12);
    check("opa_latency", rf_wr_en, 1);
    send(8'h34);
    send(8'h00);
    check("alu_latency", alu_en, 1);
    @(negedge CLK);
    check("gate_alu_wait", clk_gate_en, 1);
    alu_out       = 16'h0046;
    alu_out_valid = 1'b1;
    @(negedge CLK);
    alu_out_valid = 1'b0;
    check("gate_after_result", clk_gate_en, 0);
    settle_and_audit("aluops");
    check("aluops_tx_count", tx_seen, 3);

    // ALU without operands, MSB held off by a full FIFO
    exp_alu.push_back(4'h3);
    exp_tx.push_back(8'hCD);
    exp_tx.push_back(8'hAB);
    send(8'hDD);
    check("gate_dd", clk_gate_en, 1);
    send(8'h13);
    check("dd_alu_latency", alu_en, 1);
    alu_out       = 16'hABCD;
    alu_out_valid = 1'b1;
    @(negedge CLK);
    alu_out_valid = 1'b0;
    wait_tx("dd_lo", 10);
    tx_full = 1'b1;
    repeat (4) @(negedge CLK);
    check("dd_hi_held", tx_seen, 4);
    tx_full = 1'b0;
    wait_tx("dd_hi", 10);
    settle_and_audit("alunop");

    // Unknown opcode
    ferr_exp++;
    send(8'h55);
    check("bad_op_ferr", frame_err, 1);
    @(negedge CLK);
    check("bad_op_ferr_pulse", frame_err, 0);
    settle_and_audit("badop");

    // Reset mid-frame discards the pending write
    send(8'hAA);
    send(8'h05);
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    check("midrst_addr", rf_addr, 0);
    check("midrst_outs", {rf_wr_en, frame_err, clk_gate_en}, 0);
    RST = 1'b1;
    ferr_exp++;
    send(8'h3C);
    check("midrst_3c_ferr", frame_err, 1);
    settle_and_audit("midrst");

    // Long inter-byte gap after the opcode
`ifdef RX_CMD_TIMEOUT_EN
    ferr_exp += 3;
    send(8'hAA);
    repeat (20) @(negedge CLK);
    send(8'h05);
    send(8'h3C);
`else
    exp_wr.push_back({4'h5, 8'h3C});
    send(8'hAA);
    repeat (20) @(negedge CLK);
    send(8'h05);
    send(8'h3C);
    check("gap_wr_latency", rf_wr_en, 1);
`endif
    settle_and_audit("gap");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
